// File: rtl/multi_edge_event_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_event_detector_if
// Brief    : Stimulus/result bundle for multi_edge_event_detector.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_edge_event_detector_if #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]   sig_in;
    logic [2*CHANNELS-1:0] mode;
    logic                  clr;
    logic [CHANNELS-1:0]   evt_pulse;
    logic                  any_evt;
    logic                  tog_out;
    logic [CNT_W-1:0]      evt_count;
    logic [CHANNELS-1:0]   evt_sticky;

    modport master (
        output sig_in, mode, clr,
        input  evt_pulse, any_evt, tog_out, evt_count, evt_sticky
    );

    modport slave (
        input  sig_in, mode, clr,
        output evt_pulse, any_evt, tog_out, evt_count, evt_sticky
    );
endinterface
`default_nettype wire

// File: rtl/multi_edge_event_detector.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_event_detector
// Brief    : Per-channel programmable edge detector with pulse, toggle,
//            saturating counter and sticky flags. Optional input synchronizer
//            enabled by MULTI_EDGE_EVENT_DETECTOR_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multi_edge_event_detector #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    multi_edge_event_detector_if.slave bus
);
    localparam int                 C_SUM_W = CNT_W + 6;
    localparam logic [C_SUM_W-1:0] C_SAT   = {6'd0, {CNT_W{1'b1}}};
`ifdef MULTI_EDGE_EVENT_DETECTOR_SYNC_EN
    localparam logic [1:0]         C_ARM_EDGES = 2'd3;
`else
    localparam logic [1:0]         C_ARM_EDGES = 2'd1;
`endif

    logic [CHANNELS-1:0] det_in;
    logic [CHANNELS-1:0] in_q, in_d;
    logic [1:0]          arm_cnt_q, arm_cnt_d;
    logic                armed;
    logic [CHANNELS-1:0] rise, fall, det;
    logic [C_SUM_W-1:0]  pop, sum;

    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic                any_q, any_d;
    logic                tog_q, tog_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] sticky_q, sticky_d;

`ifdef MULTI_EDGE_EVENT_DETECTOR_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign det_in = sync2_q;
`else
    assign det_in = bus.sig_in;
`endif

    // Arming waits until in_q holds a genuine sample of the (synchronized) input.
    assign armed = (arm_cnt_q == C_ARM_EDGES);
    assign rise  = det_in & ~in_q;
    assign fall  = ~det_in & in_q;

    always_comb begin
        det = '0;
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (bus.mode[2*i +: 2])
                2'b00:   det[i] = rise[i] | fall[i];
                2'b01:   det[i] = rise[i];
                2'b10:   det[i] = fall[i];
                default: det[i] = 1'b0;
            endcase
        end
        if (!armed) begin
            det = '0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            pop = pop + C_SUM_W'(det[i]);
        end
    end

    always_comb begin
        in_d      = det_in;
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
        pulse_d   = det;
        any_d     = |det;
        tog_d     = tog_q ^ (|det);
        // Clear restarts from this edge's events so nothing detected here is lost.
        sum       = (bus.clr ? '0 : {6'd0, cnt_q}) + pop;
        cnt_d     = (sum > C_SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        sticky_d  = bus.clr ? det : (sticky_q | det);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q      <= '0;
            arm_cnt_q <= '0;
            pulse_q   <= '0;
            any_q     <= 1'b0;
            tog_q     <= 1'b0;
            cnt_q     <= '0;
            sticky_q  <= '0;
        end else begin
            in_q      <= in_d;
            arm_cnt_q <= arm_cnt_d;
            pulse_q   <= pulse_d;
            any_q     <= any_d;
            tog_q     <= tog_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
        end
    end

    assign bus.evt_pulse  = pulse_q;
    assign bus.any_evt    = any_q;
    assign bus.tog_out    = tog_q;
    assign bus.evt_count  = cnt_q;
    assign bus.evt_sticky = sticky_q;
endmodule
`default_nettype wire

// File: tb/tb_multi_edge_event_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_edge_event_detector
// Brief    : Self-checking bench for multi_edge_event_detector (default build).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multi_edge_event_detector;
    typedef struct {
        logic [2:0] sig;
        logic [5:0] mode;
        logic       clr;
        logic [2:0] pulse;
        logic       tog;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic [2:0] st;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    multi_edge_event_detector_if #(.CHANNELS(3), .CNT_W(8)) b8 ();
    multi_edge_event_detector_if #(.CHANNELS(3), .CNT_W(2)) b2 ();

    assign b2.sig_in = b8.sig_in;
    assign b2.mode   = b8.mode;
    assign b2.clr    = b8.clr;

    multi_edge_event_detector #(.CHANNELS(3), .CNT_W(8)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (b8)
    );

    multi_edge_event_detector #(.CHANNELS(3), .CNT_W(2)) dut_sat (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (b2)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [2:0] s, input logic [5:0] m, input logic c,
                                input logic [2:0] p, input logic t, input logic [7:0] n,
                                input logic [1:0] n2, input logic [2:0] st);
        vec_t v;
        v.sig = s; v.mode = m; v.clr = c; v.pulse = p;
        v.tog = t; v.cnt = n; v.cnt2 = n2; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_pulse"},  32'(b8.evt_pulse),  32'd0);
        chk({tag, "_any"},    32'(b8.any_evt),    32'd0);
        chk({tag, "_tog"},    32'(b8.tog_out),    32'd0);
        chk({tag, "_cnt"},    32'(b8.evt_count),  32'd0);
        chk({tag, "_sticky"}, 32'(b8.evt_sticky), 32'd0);
        chk({tag, "_cnt2"},   32'(b2.evt_count),  32'd0);
    endtask

    // Drive one vector before an edge, then score the outputs just after it.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        b8.sig_in = v.sig;
        b8.mode   = v.mode;
        b8.clr    = v.clr;
        sb.push_back(v);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb.pop_front();
            chk("pulse",  32'(b8.evt_pulse),  32'(e.pulse));
            chk("any",    32'(b8.any_evt),    32'(|e.pulse));
            chk("tog",    32'(b8.tog_out),    32'(e.tog));
            chk("count",  32'(b8.evt_count),  32'(e.cnt));
            chk("sticky", 32'(b8.evt_sticky), 32'(e.st));
            chk("count2", 32'(b2.evt_count),  32'(e.cnt2));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        localparam logic [5:0] M = 6'b10_01_00;
        // sig, mode, clr | pulse, tog, cnt, cnt2, sticky
        tbl.push_back(mk(3'b101, M, 1'b0, 3'b000, 1'b0, 8'd0, 2'd0, 3'b000));
        tbl.push_back(mk(3'b100, M, 1'b0, 3'b001, 1'b1, 8'd1, 2'd1, 3'b001));
        tbl.push_back(mk(3'b100, M, 1'b0, 3'b000, 1'b1, 8'd1, 2'd1, 3'b001));
        tbl.push_back(mk(3'b110, M, 1'b0, 3'b010, 1'b0, 8'd2, 2'd2, 3'b011));
        tbl.push_back(mk(3'b110, M, 1'b0, 3'b000, 1'b0, 8'd2, 2'd2, 3'b011));
        tbl.push_back(mk(3'b010, M, 1'b0, 3'b100, 1'b1, 8'd3, 2'd3, 3'b111));
        tbl.push_back(mk(3'b011, M, 1'b0, 3'b001, 1'b0, 8'd4, 2'd3, 3'b111));
        tbl.push_back(mk(3'b001, M, 1'b0, 3'b000, 1'b0, 8'd4, 2'd3, 3'b111));
        tbl.push_back(mk(3'b101, M, 1'b0, 3'b000, 1'b0, 8'd4, 2'd3, 3'b111));
        tbl.push_back(mk(3'b100, M, 1'b0, 3'b001, 1'b1, 8'd5, 2'd3, 3'b111));
        tbl.push_back(mk(3'b100, M, 1'b0, 3'b000, 1'b1, 8'd5, 2'd3, 3'b111));
        tbl.push_back(mk(3'b011, 6'b111111, 1'b0, 3'b000, 1'b1, 8'd5, 2'd3, 3'b111));
        tbl.push_back(mk(3'b011, 6'b000000, 1'b0, 3'b000, 1'b1, 8'd5, 2'd3, 3'b111));
        tbl.push_back(mk(3'b000, 6'b000000, 1'b0, 3'b011, 1'b0, 8'd7, 2'd3, 3'b111));
        tbl.push_back(mk(3'b000, 6'b000000, 1'b0, 3'b000, 1'b0, 8'd7, 2'd3, 3'b111));
        tbl.push_back(mk(3'b001, 6'b101010, 1'b0, 3'b000, 1'b0, 8'd7, 2'd3, 3'b111));
        tbl.push_back(mk(3'b000, 6'b101010, 1'b0, 3'b001, 1'b1, 8'd8, 2'd3, 3'b111));
        tbl.push_back(mk(3'b000, 6'b000000, 1'b1, 3'b000, 1'b1, 8'd0, 2'd0, 3'b000));
        tbl.push_back(mk(3'b011, 6'b000000, 1'b0, 3'b011, 1'b0, 8'd2, 2'd2, 3'b011));
        tbl.push_back(mk(3'b001, 6'b000000, 1'b0, 3'b010, 1'b1, 8'd3, 2'd3, 3'b011));
        tbl.push_back(mk(3'b101, 6'b000000, 1'b1, 3'b100, 1'b0, 8'd1, 2'd1, 3'b100));
        tbl.push_back(mk(3'b101, 6'b000000, 1'b0, 3'b000, 1'b0, 8'd1, 2'd1, 3'b100));
        tbl.push_back(mk(3'b100, 6'b000000, 1'b0, 3'b001, 1'b1, 8'd2, 2'd2, 3'b101));
        tbl.push_back(mk(3'b101, 6'b000000, 1'b0, 3'b001, 1'b0, 8'd3, 2'd3, 3'b101));
        tbl.push_back(mk(3'b100, 6'b000000, 1'b0, 3'b001, 1'b1, 8'd4, 2'd3, 3'b101));
        tbl.push_back(mk(3'b101, 6'b000000, 1'b0, 3'b001, 1'b0, 8'd5, 2'd3, 3'b101));

        // Inputs high through reset must not produce an event after release.
        b8.sig_in = 3'b111;
        b8.mode   = 6'b000000;
        b8.clr    = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rst_chk("reset");
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            apply(mk(3'b111, 6'b000000, 1'b0, 3'b000, 1'b0, 8'd0, 2'd0, 3'b000));
        end

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        // Asynchronous reset mid-burst, checked before the next rising edge.
        @(negedge clock);
        b8.sig_in = 3'b100;
        #2;
        reset_n = 1'b0;
        #1;
        rst_chk("async_reset");
        @(posedge clock);
        #1;
        rst_chk("held_reset");
        reset_n = 1'b1;
        apply(mk(3'b101, 6'b000000, 1'b0, 3'b000, 1'b0, 8'd0, 2'd0, 3'b000));

        // Six single events: the narrow counter must stop at 3.
        for (int k = 0; k < 6; k++) begin
            apply(mk((k % 2 == 0) ? 3'b100 : 3'b101, 6'b000000, 1'b0, 3'b001,
                     (k % 2 == 0) ? 1'b1 : 1'b0, 8'(k + 1),
                     (k + 1 > 3) ? 2'd3 : 2'(k + 1), 3'b001));
        end

        // Sub-period glitch between edges is invisible.
        @(posedge clock);
        #2;
        b8.sig_in = 3'b111;
        #2;
        b8.sig_in = 3'b101;
        apply(mk(3'b101, 6'b000000, 1'b0, 3'b000, 1'b0, 8'd6, 2'd3, 3'b001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
